mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 58 +++++
 rtl/mem_arbiter.sv | 151 +++++++++++++++
 tb/tb_mem_arbiter.sv | 493 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: fetch port, load/store port and the shared memory port.
//
// Signal groups
//   if_*  : instruction-fetch requester (req/addr in, gnt/rvalid/rdata out of the arbiter)
//   ls_*  : load/store requester (req/we/addr/wdata/wlen in, gnt/rvalid/rdata out)
//   mem_* : shared memory port (valid/addr/wen/wdata/wlen out, ready/rvalid/rdata in)
//
// Modports
//   slave  : the arbiter's view (requesters and memory responses are inputs)
//   master : the environment's view (requesters plus memory model)
interface mem_arbiter_if #(
  parameter int unsigned DW = 64,
  parameter int unsigned AW = 64
) ();

  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;

  logic          ls_req;
  logic          ls_we;
  logic [AW-1:0] ls_addr;
  logic [DW-1:0] ls_wdata;
  logic [3:0]    ls_wlen;
  logic          ls_gnt;
  logic          ls_rvalid;
  logic [DW-1:0] ls_rdata;

  logic          mem_valid;
  logic          mem_ready;
  logic [AW-1:0] mem_addr;
  logic          mem_wen;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    mem_wlen;
  logic          mem_rvalid;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  ls_req, ls_we, ls_addr, ls_wdata, ls_wlen,
    output ls_gnt, ls_rvalid, ls_rdata,
    output mem_valid, mem_addr, mem_wen, mem_wdata, mem_wlen,
    input  mem_ready, mem_rvalid, mem_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output ls_req, ls_we, ls_addr, ls_wdata, ls_wlen,
    input  ls_gnt, ls_rvalid, ls_rdata,
    input  mem_valid, mem_addr, mem_wen, mem_wdata, mem_wlen,
    output mem_ready, mem_rvalid, mem_rdata
  );

endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one memory port between instruction fetch (IF) and
// load/store (LS). One transaction is in flight at a time; contested grants alternate.
//
// Ports
//   clk  : sole clock, rising edge
//   rstn : asynchronous active-low reset; all outputs are forced to 0 while low
//   bus  : mem_arbiter_if.slave carrying the IF, LS and memory port signals
//
// Flow: IDLE grants and latches a request, REQ presents it on the memory port until
// mem_ready, WAIT holds until mem_rvalid. A response that arrives together with
// mem_ready completes straight from REQ, giving one transaction every two cycles.
module mem_arbiter #(
  parameter int unsigned DW = 64,
  parameter int unsigned AW = 64
) (
  input logic          clk,
  input logic          rstn,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait
  } state_e;

  typedef enum logic {
    OwnIf = 1'b0,
    OwnLs = 1'b1
  } owner_e;

  state_e        state_q, state_d;
  owner_e        owner_q, owner_d;
  owner_e        last_q, last_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          wen_q, wen_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [3:0]    wlen_q, wlen_d;

  logic grant_if;
  logic grant_ls;
  logic complete;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    addr_d   = addr_q;
    wen_d    = wen_q;
    wdata_d  = wdata_q;
    wlen_d   = wlen_q;
    grant_if = 1'b0;
    grant_ls = 1'b0;
    complete = 1'b0;

    unique case (state_q)
      StIdle: begin
        // LS wins when it is alone, or when both ask and IF was served last.
        if (bus.ls_req && (!bus.if_req || (last_q == OwnIf))) begin
          grant_ls = 1'b1;
          owner_d  = OwnLs;
          last_d   = OwnLs;
          addr_d   = bus.ls_addr;
          wen_d    = bus.ls_we;
          wdata_d  = bus.ls_wdata;
          // Loads carry no byte count onto the memory port.
          wlen_d   = bus.ls_we ? bus.ls_wlen : 4'd0;
          state_d  = StReq;
        end else if (bus.if_req) begin
          grant_if = 1'b1;
          owner_d  = OwnIf;
          last_d   = OwnIf;
          addr_d   = bus.if_addr;
          wen_d    = 1'b0;
          wdata_d  = '0;
          wlen_d   = 4'd0;
          state_d  = StReq;
        end
      end

      StReq: begin
        if (bus.mem_ready) begin
          if (bus.mem_rvalid) begin
            complete = 1'b1;
            state_d  = StIdle;
          end else begin
            state_d  = StWait;
          end
        end
      end

      StWait: begin
        if (bus.mem_rvalid) begin
          complete = 1'b1;
          state_d  = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      owner_q <= OwnIf;
      last_q  <= OwnIf;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wlen_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      wlen_q  <= wlen_d;
    end
  end

  // Grants are combinational on the request, so they are masked by rstn directly; the
  // registered paths are already zero because state and fields clear asynchronously.
  assign bus.if_gnt    = rstn & grant_if;
  assign bus.ls_gnt    = rstn & grant_ls;

  // complete only fires in REQ (with mem_ready) or WAIT, so stray responses are dropped.
  assign bus.if_rvalid = complete & (owner_q == OwnIf);
  assign bus.ls_rvalid = complete & (owner_q == OwnLs);
  assign bus.if_rdata  = rstn ? bus.mem_rdata : '0;
  assign bus.ls_rdata  = rstn ? bus.mem_rdata : '0;

  assign bus.mem_valid = (state_q == StReq);
  assign bus.mem_wen   = (state_q == StReq) & wen_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_wlen  = wlen_q;

  a_gnt_onehot: assert property (@(posedge clk) disable iff (!rstn)
    !(bus.if_gnt && bus.ls_gnt));

  a_wen_needs_valid: assert property (@(posedge clk) disable iff (!rstn)
    bus.mem_wen |-> bus.mem_valid);

  a_req_stable: assert property (@(posedge clk) disable iff (!rstn)
    (bus.mem_valid && !bus.mem_ready) |=>
      (bus.mem_valid && $stable(bus.mem_addr) && $stable(bus.mem_wdata) &&
       $stable(bus.mem_wen) && $stable(bus.mem_wlen)));

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by a randomized run
// checked against a transaction-level model (busy flag, round-robin pointer, expected
// request fields). Inputs change 1 time unit after the rising edge, outputs are sampled
// 4 units after the edge.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rstn;
  int   checks_total  = 0;
  int   checks_passed = 0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.DW(64), .AW(64)) bus ();

  mem_arbiter #(.DW(64), .AW(64)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic idle_inputs();
    bus.if_req     = 1'b0;
    bus.if_addr    = '0;
    bus.ls_req     = 1'b0;
    bus.ls_we      = 1'b0;
    bus.ls_addr    = '0;
    bus.ls_wdata   = '0;
    bus.ls_wlen    = 4'd0;
    bus.mem_ready  = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
  endtask

  // Ends 1 unit after a rising edge with rstn released; that cycle is idle.
  task automatic do_reset();
    idle_inputs();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn           = 1'b0;
    bus.if_req     = 1'b1;
    bus.if_addr    = 64'h1234;
    bus.ls_req     = 1'b1;
    bus.ls_we      = 1'b1;
    bus.ls_addr    = 64'h5678;
    bus.ls_wdata   = 64'hFFFF_0000_FFFF_0000;
    bus.ls_wlen    = 4'd8;
    bus.mem_ready  = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 64'hA5A5_A5A5_A5A5_A5A5;
    repeat (2) begin
      @(posedge clk);
      #4;
      checks_total++;
      if ({bus.if_gnt, bus.ls_gnt, bus.if_rvalid, bus.ls_rvalid, bus.mem_valid, bus.mem_wen}
          !== 6'b0)
        $display("FAIL reset_ctrl: got %b want 000000",
                 {bus.if_gnt, bus.ls_gnt, bus.if_rvalid, bus.ls_rvalid, bus.mem_valid,
                  bus.mem_wen});
      else checks_passed++;
      checks_total++;
      if ({bus.if_rdata, bus.ls_rdata, bus.mem_addr, bus.mem_wdata, bus.mem_wlen} !== '0)
        $display("FAIL reset_data: got if_rdata=%h ls_rdata=%h addr=%h wdata=%h wlen=%h want 0",
                 bus.if_rdata, bus.ls_rdata, bus.mem_addr, bus.mem_wdata, bus.mem_wlen);
      else checks_passed++;
    end
    idle_inputs();
    @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  task automatic test_single_fetch();
    do_reset();
    tick();
    bus.if_req  = 1'b1;
    bus.if_addr = 64'h8000_0000;
    settle();
    checks_total++;
    if ({bus.if_gnt, bus.ls_gnt, bus.mem_valid} !== 3'b100)
      $display("FAIL fetch_gnt: got if_gnt/ls_gnt/mem_valid=%b want 100",
               {bus.if_gnt, bus.ls_gnt, bus.mem_valid});
    else checks_passed++;

    tick();
    bus.if_req     = 1'b0;
    bus.mem_ready  = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 64'h13;
    settle();
    checks_total++;
    if ({bus.mem_valid, bus.mem_addr, bus.mem_wen, bus.mem_wlen} !== {1'b1, 64'h8000_0000, 5'b0})
      $display("FAIL fetch_req: got valid=%b addr=%h wen=%b wlen=%0d want 1/80000000/0/0",
               bus.mem_valid, bus.mem_addr, bus.mem_wen, bus.mem_wlen);
    else checks_passed++;
    checks_total++;
    if ({bus.if_rvalid, bus.ls_rvalid, bus.if_rdata} !== {2'b10, 64'h13})
      $display("FAIL fetch_resp: got if_rvalid=%b ls_rvalid=%b if_rdata=%h want 1/0/13",
               bus.if_rvalid, bus.ls_rvalid, bus.if_rdata);
    else checks_passed++;

    tick();
    idle_inputs();
    settle();
    checks_total++;
    if ({bus.mem_valid, bus.if_rvalid} !== 2'b00)
      $display("FAIL fetch_done: got mem_valid/if_rvalid=%b want 00",
               {bus.mem_valid, bus.if_rvalid});
    else checks_passed++;
  endtask

  task automatic test_round_robin();
    logic [1:0]  want_gnt;
    logic [1:0]  want_rv;
    logic [63:0] want_addr;
    do_reset();
    for (int k = 0; k < 12; k++) begin
      tick();
      bus.if_req     = 1'b1;
      bus.if_addr    = 64'h0000_1000;
      bus.ls_req     = 1'b1;
      bus.ls_we      = 1'b0;
      bus.ls_addr    = 64'h0000_2000;
      bus.mem_ready  = 1'b1;
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = {32'h0, 32'(k)};
      settle();
      if ((k % 2) == 0) begin
        want_gnt = ((k % 4) == 0) ? 2'b01 : 2'b10;
        checks_total++;
        if ({bus.if_gnt, bus.ls_gnt, bus.if_rvalid, bus.ls_rvalid} !== {want_gnt, 2'b00})
          $display("FAIL rr_grant k=%0d: got gnt if/ls=%b rvalid if/ls=%b want %b/00", k,
                   {bus.if_gnt, bus.ls_gnt}, {bus.if_rvalid, bus.ls_rvalid}, want_gnt);
        else checks_passed++;
      end else begin
        want_rv   = ((k % 4) == 1) ? 2'b01 : 2'b10;
        want_addr = ((k % 4) == 1) ? 64'h0000_2000 : 64'h0000_1000;
        checks_total++;
        if ({bus.if_gnt, bus.ls_gnt, bus.mem_valid, bus.mem_addr, bus.if_rvalid, bus.ls_rvalid}
            !== {3'b001, want_addr, want_rv})
          $display("FAIL rr_busy k=%0d: got gnt=%b valid=%b addr=%h rvalid=%b want 00/1/%h/%b",
                   k, {bus.if_gnt, bus.ls_gnt}, bus.mem_valid, bus.mem_addr,
                   {bus.if_rvalid, bus.ls_rvalid}, want_addr, want_rv);
        else checks_passed++;
      end
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_store_stall();
    tick();
    bus.ls_req   = 1'b1;
    bus.ls_we    = 1'b1;
    bus.ls_addr  = 64'h8000_1000;
    bus.ls_wdata = 64'hDEAD_BEEF;
    bus.ls_wlen  = 4'd4;
    settle();
    checks_total++;
    if ({bus.if_gnt, bus.ls_gnt} !== 2'b01)
      $display("FAIL store_gnt: got if/ls=%b want 01", {bus.if_gnt, bus.ls_gnt});
    else checks_passed++;
    for (int c = 1; c <= 4; c++) begin
      tick();
      bus.ls_req    = 1'b0;
      bus.ls_wdata  = 64'h0;
      bus.ls_wlen   = 4'd1;
      bus.mem_ready = (c == 4);
      settle();
      checks_total++;
      if ({bus.mem_valid, bus.mem_wen, bus.mem_wlen, bus.mem_addr, bus.mem_wdata}
          !== {2'b11, 4'd4, 64'h8000_1000, 64'hDEAD_BEEF})
        $display("FAIL store_hold c=%0d: got valid=%b wen=%b wlen=%0d addr=%h wdata=%h", c,
                 bus.mem_valid, bus.mem_wen, bus.mem_wlen, bus.mem_addr, bus.mem_wdata);
      else checks_passed++;
      checks_total++;
      if (bus.ls_rvalid !== 1'b0)
        $display("FAIL store_early_rvalid c=%0d: got %b want 0", c, bus.ls_rvalid);
      else checks_passed++;
    end
    tick();
    bus.mem_ready  = 1'b0;
    bus.mem_rvalid = 1'b1;
    settle();
    checks_total++;
    if ({bus.mem_valid, bus.mem_wen, bus.if_rvalid, bus.ls_rvalid} !== 4'b0001)
      $display("FAIL store_ack: got valid/wen/if_rv/ls_rv=%b want 0001",
               {bus.mem_valid, bus.mem_wen, bus.if_rvalid, bus.ls_rvalid});
    else checks_passed++;
    tick();
    idle_inputs();
  endtask

  task automatic test_wait_load();
    logic [63:0] data;
    data = {$urandom, $urandom};
    tick();
    bus.ls_req  = 1'b1;
    bus.ls_we   = 1'b0;
    bus.ls_addr = 64'h0000_0040;
    bus.ls_wlen = 4'd8;
    settle();
    checks_total++;
    if (bus.ls_gnt !== 1'b1) $display("FAIL load_gnt: got %b want 1", bus.ls_gnt);
    else checks_passed++;
    tick();
    bus.ls_req    = 1'b0;
    bus.mem_ready = 1'b1;
    settle();
    checks_total++;
    if ({bus.mem_valid, bus.mem_wen, bus.mem_wlen, bus.mem_addr} !== {2'b10, 4'd0, 64'h40})
      $display("FAIL load_req: got valid=%b wen=%b wlen=%0d addr=%h want 1/0/0/40",
               bus.mem_valid, bus.mem_wen, bus.mem_wlen, bus.mem_addr);
    else checks_passed++;
    for (int c = 2; c <= 4; c++) begin
      tick();
      bus.mem_ready  = 1'b0;
      bus.if_req     = 1'b1;
      bus.if_addr    = 64'h0000_0100;
      bus.mem_rvalid = (c == 4);
      bus.mem_rdata  = data;
      settle();
      checks_total++;
      if ({bus.mem_valid, bus.if_gnt, bus.if_rvalid, bus.ls_rvalid} !== {3'b000, c == 4})
        $display("FAIL load_wait c=%0d: got valid/if_gnt/if_rv/ls_rv=%b want 000%0d", c,
                 {bus.mem_valid, bus.if_gnt, bus.if_rvalid, bus.ls_rvalid}, c == 4);
      else checks_passed++;
    end
    checks_total++;
    if (bus.ls_rdata !== data)
      $display("FAIL load_rdata: got %h want %h", bus.ls_rdata, data);
    else checks_passed++;
    tick();
    bus.mem_rvalid = 1'b0;
    settle();
    checks_total++;
    if ({bus.if_gnt, bus.ls_gnt} !== 2'b10)
      $display("FAIL load_then_fetch_gnt: got if/ls=%b want 10", {bus.if_gnt, bus.ls_gnt});
    else checks_passed++;
    tick();
    bus.if_req     = 1'b0;
    bus.mem_ready  = 1'b1;
    bus.mem_rvalid = 1'b1;
    settle();
    checks_total++;
    if ({bus.mem_addr, bus.if_rvalid, bus.ls_rvalid} !== {64'h100, 2'b10})
      $display("FAIL load_then_fetch_resp: got addr=%h rvalid if/ls=%b want 100/10",
               bus.mem_addr, {bus.if_rvalid, bus.ls_rvalid});
    else checks_passed++;
    tick();
    idle_inputs();
  endtask

  task automatic test_reset_in_wait();
    tick();
    bus.ls_req  = 1'b1;
    bus.ls_addr = 64'h0000_0080;
    settle();
    tick();
    bus.ls_req    = 1'b0;
    bus.mem_ready = 1'b1;
    settle();
    tick();
    bus.mem_ready = 1'b0;
    bus.if_req    = 1'b1;
    settle();
    rstn = 1'b0;
    #1;
    checks_total++;
    if ({bus.if_gnt, bus.ls_gnt, bus.if_rvalid, bus.ls_rvalid, bus.mem_valid, bus.mem_wen,
         bus.mem_addr} !== '0)
      $display("FAIL rst_wait_now: got ctrl=%b addr=%h want 0",
               {bus.if_gnt, bus.ls_gnt, bus.if_rvalid, bus.ls_rvalid, bus.mem_valid,
                bus.mem_wen}, bus.mem_addr);
    else checks_passed++;
    tick();
    bus.mem_rvalid = 1'b1;
    settle();
    checks_total++;
    if ({bus.if_rvalid, bus.ls_rvalid, bus.if_gnt} !== 3'b000)
      $display("FAIL rst_wait_rvalid: got %b want 000",
               {bus.if_rvalid, bus.ls_rvalid, bus.if_gnt});
    else checks_passed++;
    tick();
    rstn       = 1'b1;
    bus.if_req = 1'b0;
    settle();
    checks_total++;
    if ({bus.if_rvalid, bus.ls_rvalid, bus.mem_valid} !== 3'b000)
      $display("FAIL rst_release_rvalid: got %b want 000",
               {bus.if_rvalid, bus.ls_rvalid, bus.mem_valid});
    else checks_passed++;
    tick();
    idle_inputs();
    bus.if_req  = 1'b1;
    bus.if_addr = 64'h0000_0200;
    settle();
    checks_total++;
    if ({bus.if_gnt, bus.ls_gnt} !== 2'b10)
      $display("FAIL rst_resume_gnt: got %b want 10", {bus.if_gnt, bus.ls_gnt});
    else checks_passed++;
    tick();
    bus.if_req     = 1'b0;
    bus.mem_ready  = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 64'h77;
    settle();
    checks_total++;
    if ({bus.mem_addr, bus.if_rvalid, bus.if_rdata} !== {64'h200, 1'b1, 64'h77})
      $display("FAIL rst_resume_resp: got addr=%h if_rvalid=%b if_rdata=%h want 200/1/77",
               bus.mem_addr, bus.if_rvalid, bus.if_rdata);
    else checks_passed++;
    tick();
    idle_inputs();
  endtask

  task automatic test_idle_rvalid();
    for (int c = 0; c < 3; c++) begin
      tick();
      idle_inputs();
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = {$urandom, $urandom};
      settle();
      checks_total++;
      if ({bus.if_rvalid, bus.ls_rvalid, bus.mem_valid} !== 3'b000)
        $display("FAIL idle_rvalid c=%0d: got if/ls/valid=%b want 000", c,
                 {bus.if_rvalid, bus.ls_rvalid, bus.mem_valid});
      else checks_passed++;
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_random(input int n);
    // Reference model: whether a transaction is outstanding, whether memory has taken it,
    // who owns it, who was served last, and the request fields it must carry.
    logic        m_busy, m_acc, m_owner_ls, m_last_ls;
    logic [63:0] e_addr, e_wdata;
    logic        e_wen;
    logic [3:0]  e_wlen;
    logic        if_pend, ls_pend;
    logic [63:0] r_if_addr, r_ls_addr, r_ls_wdata;
    logic        r_ls_we;
    logic [3:0]  r_ls_wlen;
    logic        mem_out;
    logic        g_if, g_ls, win_ls, exp_valid, resp;

    m_busy = 1'b0; m_acc = 1'b0; m_owner_ls = 1'b0; m_last_ls = 1'b0;
    e_addr = '0; e_wdata = '0; e_wen = 1'b0; e_wlen = 4'd0;
    if_pend = 1'b0; ls_pend = 1'b0; mem_out = 1'b0;
    r_if_addr = '0; r_ls_addr = '0; r_ls_wdata = '0; r_ls_we = 1'b0; r_ls_wlen = 4'd0;
    do_reset();

    for (int c = 0; c < n; c++) begin
      tick();
      if (!if_pend && ($urandom_range(1, 0) == 1)) begin
        if_pend   = 1'b1;
        r_if_addr = {$urandom, $urandom};
      end
      if (!ls_pend && ($urandom_range(1, 0) == 1)) begin
        ls_pend    = 1'b1;
        r_ls_addr  = {$urandom, $urandom};
        r_ls_wdata = {$urandom, $urandom};
        r_ls_we    = 1'($urandom_range(1, 0));
        r_ls_wlen  = 4'(1 << $urandom_range(3, 0));
      end
      bus.if_req   = if_pend;
      bus.if_addr  = r_if_addr;
      bus.ls_req   = ls_pend;
      bus.ls_addr  = r_ls_addr;
      bus.ls_wdata = r_ls_wdata;
      bus.ls_we    = r_ls_we;
      bus.ls_wlen  = r_ls_wlen;

      // Memory: random ready, response same cycle or later, plus stray pulses when idle.
      bus.mem_ready = 1'($urandom_range(1, 0));
      if (bus.mem_valid && bus.mem_ready) begin
        bus.mem_rvalid = 1'($urandom_range(1, 0));
        if (!bus.mem_rvalid) mem_out = 1'b1;
      end else if (mem_out) begin
        bus.mem_rvalid = ($urandom_range(2, 0) == 0);
        if (bus.mem_rvalid) mem_out = 1'b0;
      end else begin
        bus.mem_rvalid = ($urandom_range(7, 0) == 0);
      end
      bus.mem_rdata = {$urandom, $urandom};
      settle();

      g_if = 1'b0;
      g_ls = 1'b0;
      if (!m_busy && (if_pend || ls_pend)) begin
        win_ls = (if_pend && ls_pend) ? !m_last_ls : ls_pend;
        g_ls   = win_ls;
        g_if   = !win_ls;
      end
      checks_total++;
      if ({bus.if_gnt, bus.ls_gnt} !== {g_if, g_ls})
        $display("FAIL rand_gnt c=%0d: got if/ls=%b want %b", c,
                 {bus.if_gnt, bus.ls_gnt}, {g_if, g_ls});
      else checks_passed++;

      exp_valid = m_busy && !m_acc;
      checks_total++;
      if (bus.mem_valid !== exp_valid)
        $display("FAIL rand_valid c=%0d: got %b want %b", c, bus.mem_valid, exp_valid);
      else checks_passed++;

      checks_total++;
      if (exp_valid) begin
        if ({bus.mem_addr, bus.mem_wen, bus.mem_wlen} !== {e_addr, e_wen, e_wlen} ||
            (e_wen && (bus.mem_wdata !== e_wdata)))
          $display("FAIL rand_fields c=%0d: got addr=%h wen=%b wlen=%0d wdata=%h want %h/%b/%0d/%h",
                   c, bus.mem_addr, bus.mem_wen, bus.mem_wlen, bus.mem_wdata,
                   e_addr, e_wen, e_wlen, e_wdata);
        else checks_passed++;
      end else begin
        if (bus.mem_wen !== 1'b0)
          $display("FAIL rand_wen_idle c=%0d: got %b want 0", c, bus.mem_wen);
        else checks_passed++;
      end

      resp = bus.mem_rvalid && m_busy && (m_acc || (exp_valid && bus.mem_ready));
      checks_total++;
      if ({bus.if_rvalid, bus.ls_rvalid} !== {resp && !m_owner_ls, resp && m_owner_ls})
        $display("FAIL rand_rvalid c=%0d: got if/ls=%b want %b", c,
                 {bus.if_rvalid, bus.ls_rvalid}, {resp && !m_owner_ls, resp && m_owner_ls});
      else checks_passed++;
      if (resp) begin
        checks_total++;
        if ((m_owner_ls ? bus.ls_rdata : bus.if_rdata) !== bus.mem_rdata)
          $display("FAIL rand_rdata c=%0d: got %h want %h", c,
                   m_owner_ls ? bus.ls_rdata : bus.if_rdata, bus.mem_rdata);
        else checks_passed++;
      end

      if (resp) begin
        m_busy = 1'b0;
        m_acc  = 1'b0;
      end else if (exp_valid && bus.mem_ready) begin
        m_acc = 1'b1;
      end
      if (g_if || g_ls) begin
        m_busy     = 1'b1;
        m_acc      = 1'b0;
        m_owner_ls = g_ls;
        m_last_ls  = g_ls;
        e_addr     = g_ls ? r_ls_addr : r_if_addr;
        e_wen      = g_ls && r_ls_we;
        e_wlen     = (g_ls && r_ls_we) ? r_ls_wlen : 4'd0;
        e_wdata    = r_ls_wdata;
      end
      if (bus.if_gnt) if_pend = 1'b0;
      if (bus.ls_gnt) ls_pend = 1'b0;
    end
    tick();
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rstn = 1'b1;
    #2;
    test_reset();
    test_single_fetch();
    test_round_robin();
    test_store_stall();
    test_wait_load();
    test_reset_in_wait();
    test_idle_rvalid();
    test_random(3000);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at time %0t, limit 500000", $time);
    $fatal(1);
  end

endmodule
